a2d_arbiter: RTL and testbench
==============================

Name: a2d_arbiter

Overview:
Shares the single A2D converter interface between two requesters: requester 0 is the motion controller's IR sensor sweep, requester 1 is an auxiliary monitor such as battery or temperature. The block arbitrates requests round-robin, drives channel select and the start strobe, waits for conversion complete, and returns the captured result with a per-requester done pulse. It sits between the requesters and the A2D interface block.

Parameters:
RES_W, 12, conversion result width
CH_W, 3, channel select width
TIMEOUT_CYCLES, 1024, watchdog limit in clocks; used only with A2D_TIMEOUT_EN

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 conversion request, level; held until done0
chnl0  input  CH_W  requester 0 channel, stable while req0 high
req1  input  1  requester 1 conversion request, level; held until done1
chnl1  input  CH_W  requester 1 channel, stable while req1 high
gnt  output  2  one-hot grant; bit n means requester n owns the A2D
done0  output  1  one-cycle pulse: requester 0 result valid on res_out
done1  output  1  one-cycle pulse: requester 1 result valid on res_out
res_out  output  RES_W  captured result, held until the next capture
busy  output  1  high in any state other than IDLE
strt_cnv  output  1  one-cycle start strobe to the A2D
chnnl  output  CH_W  registered channel select to the A2D
cnv_cmplt  input  1  A2D conversion complete, single-cycle pulse
res  input  RES_W  A2D result, valid in the cnv_cmplt cycle
err  output  1  timeout pulse; constant 0 when A2D_TIMEOUT_EN is undefined

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: gnt=0, done0/done1=0, res_out=0, busy=0, strt_cnv=0, chnnl=0, err=0, state=IDLE, last_gnt=1. With last_gnt=1, requester 0 wins the first tie.
- State IDLE:
  - Requests are evaluated combinationally each cycle.
  - Only one req high: grant that requester.
  - Both high: grant the requester that is not last_gnt.
  - On a grant, at the next edge: set gnt, set last_gnt, register chnnl from the winner's chnl, go to START.
- State START: strt_cnv=1 for exactly this one cycle; chnnl is already stable. Go to WAIT.
- State WAIT:
  - Hold gnt and chnnl.
  - On cnv_cmplt=1: res_out<=res, go to DONE.
  - cnv_cmplt seen in the START cycle is ignored. cnv_cmplt in IDLE or DONE is ignored.
- State DONE:
  - done[gnt]=1 for this cycle; res_out is valid.
  - Next edge: gnt<=0, go to IDLE.
  - The requester drops req on the edge that ends DONE, so IDLE sees the updated req the following cycle.
- Latency: req sampled in IDLE at cycle 0 gives strt_cnv at cycle 1. cnv_cmplt at cycle k gives done/res_out at cycle k+1 and IDLE at cycle k+2. Minimum back-to-back period is 4 cycles plus conversion time.
- Request deasserted mid-conversion: the conversion still completes, done still pulses and res_out is updated. There is no abort.
- A request arriving in any state other than IDLE is held off until IDLE. A losing requester is served next.
- Reset asserted mid-operation: immediate return to reset values. No done pulse is issued, and no result is captured from a cnv_cmplt that arrives during reset.
- chnnl and res_out are registered; there are no combinational paths from req to strt_cnv.

Optional Feature:
A2D_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 with no cnv_cmplt, go to DONE with res_out unchanged.
  - In that DONE cycle both err=1 and done[gnt]=1.
  - cnv_cmplt in the same cycle as the terminal count has priority: normal capture, err=0.
- Undefined: no counter, err is tied 0, and WAIT waits indefinitely.

Test Plan:
- Single request: req0=1, chnl0=3; cnv_cmplt 10 cycles after strt_cnv with res=12'hFFF -> strt_cnv 1 cycle after req, chnnl=3, gnt=01, done0 pulses 1 cycle after cnv_cmplt, res_out=12'hFFF, IDLE 2 cycles after cnv_cmplt.
- Tie after reset: req0 and req1 rise together (chnl0=1, chnl1=6) -> requester 0 served first with chnnl=1; then requester 1 with chnnl=6; done0 precedes done1.
- Round-robin fairness: both held high for 4 conversions with res 12'h3FF/12'hFFF -> grants alternate 0,1,0,1; each done paired with the correct res_out.
- Spurious/early complete: cnv_cmplt pulsed in IDLE and in the START cycle -> ignored, no done, res_out unchanged; a later WAIT-cycle cnv_cmplt completes normally.
- Reset mid-conversion: rst_n low during WAIT -> all outputs 0 immediately, no done; after release, the next req is served normally with requester 0 winning ties.
- Timeout (A2D_TIMEOUT_EN, TIMEOUT_CYCLES=16): no cnv_cmplt -> err and done1 pulse together 16 cycles after entering WAIT, res_out unchanged; without the macro, busy remains 1 indefinitely.

Source files
------------

// File: rtl/a2d_arbiter.sv
// a2d_arbiter: round-robin arbiter sharing one A2D converter between two requesters.
// Ports: req0/chnl0, req1/chnl1 requests in; gnt/done0/done1/res_out/busy back to the
//   requesters; strt_cnv/chnnl out to the A2D; cnv_cmplt/res in from the A2D; err watchdog pulse.
// Latency: strt_cnv one cycle after a request is seen in IDLE; done pulses one cycle after
//   cnv_cmplt, and the block is back in IDLE the cycle after that.
// Backpressure: requests arriving while busy are held off until IDLE; a losing requester is
//   served next.
// Optional macro A2D_TIMEOUT_EN: adds a WAIT watchdog that forces DONE with err after
//   TIMEOUT_CYCLES clocks. When it is undefined, err is tied low.
module a2d_arbiter #(
  parameter int RES_W          = 12,
  parameter int CH_W           = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [CH_W-1:0]  chnl0,
  input  logic             req1,
  input  logic [CH_W-1:0]  chnl1,
  output logic [1:0]       gnt,
  output logic             done0,
  output logic             done1,
  output logic [RES_W-1:0] res_out,
  output logic             busy,
  output logic             strt_cnv,
  output logic [CH_W-1:0]  chnnl,
  input  logic             cnv_cmplt,
  input  logic [RES_W-1:0] res,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t state, state_nxt;
  logic   last_gnt;     // index of the requester served most recently
  logic   win_vld;
  logic   win_id;
  logic   tmo_hit;      // watchdog expired in this WAIT cycle

  // Winner selection. On a tie, the requester not served last goes first.
  always_comb begin
    win_vld = req0 | req1;
    win_id  = (req0 && req1) ? ~last_gnt : req1;
  end

`ifdef A2D_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_flag;

  // A completion in the terminal-count cycle takes priority over the timeout.
  assign tmo_hit = (state == WAIT) && !cnv_cmplt &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // The counter clears while in START, so it reads 0 in the first WAIT cycle.
  // tmo_flag is high only during the DONE cycle that follows an expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      tmo_flag <= tmo_hit;
      if (state == START)     tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign err = tmo_flag;
`else
  assign tmo_hit = 1'b0;
  // TIMEOUT_CYCLES only matters with the watchdog; the compare folds to a constant.
  assign err     = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (win_vld) state_nxt = START;
      START: state_nxt = WAIT;   // a cnv_cmplt seen here is not from our start
      WAIT:  if (cnv_cmplt || tmo_hit) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    strt_cnv = (state == START);
    busy     = (state != IDLE);
    done0    = (state == DONE) && gnt[0];
    done1    = (state == DONE) && gnt[1];
  end

  // Grant, channel and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= 2'b00;
      last_gnt <= 1'b1;
      chnnl    <= '0;
      res_out  <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          gnt      <= win_id ? 2'b10 : 2'b01;
          last_gnt <= win_id;
          chnnl    <= win_id ? chnl1 : chnl0;
        end
        WAIT: if (cnv_cmplt) res_out <= res;
        DONE: gnt <= 2'b00;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_arbiter.sv
module tb_a2d_arbiter;

  localparam int RES_W = 12;
  localparam int CH_W  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1;
  logic [CH_W-1:0]  chnl0, chnl1;
  logic [1:0]       gnt;
  logic             done0, done1;
  logic [RES_W-1:0] res_out;
  logic             busy, strt_cnv;
  logic [CH_W-1:0]  chnnl;
  logic             cnv_cmplt;
  logic [RES_W-1:0] res;
  logic             err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: which requests are outstanding, their channels, who was served
  // last, and the result the requesters should currently see.
  bit               pend0, pend1;
  logic [CH_W-1:0]  ch0, ch1;
  int               m_last;
  logic [RES_W-1:0] m_res;

  a2d_arbiter #(.RES_W(RES_W), .CH_W(CH_W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .chnl0(chnl0), .req1(req1), .chnl1(chnl1),
    .gnt(gnt), .done0(done0), .done1(done1), .res_out(res_out),
    .busy(busy), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Raise a request with a channel (no effect if that requester is already waiting).
  task automatic raise(input int which, input logic [CH_W-1:0] ch);
    if (which == 0 && !pend0) begin pend0 = 1; ch0 = ch; chnl0 = ch; req0 = 1'b1; end
    if (which == 1 && !pend1) begin pend1 = 1; ch1 = ch; chnl1 = ch; req1 = 1'b1; end
  endtask

  task automatic drop(input int which);
    if (which == 0) begin pend0 = 0; req0 = 1'b0; end
    else            begin pend1 = 0; req1 = 1'b0; end
  endtask

  // Who the rules say gets the converter next.
  function automatic int pick();
    if (pend0 && pend1) return 1 - m_last;
    if (pend0)          return 0;
    return 1;
  endfunction

  // One full conversion. Entered at a negedge with the block in IDLE and at least one
  // request driven. spurious: pulse cnv_cmplt in IDLE and in START (both must be ignored).
  // drop_mid: the winner withdraws its request during WAIT; the result still arrives.
  task automatic serve(input int delay, input logic [RES_W-1:0] r,
                       input bit spurious, input bit drop_mid);
    int         w;
    logic [1:0] eg;
    w  = pick();
    eg = (w == 0) ? 2'b01 : 2'b10;
    m_last = w;
    if (spurious) begin cnv_cmplt = 1'b1; res = ~r; end
    @(negedge clk);
    cnv_cmplt = 1'b0;
    chk("start_strb",  strt_cnv, 1);
    chk("start_gnt",   gnt, eg);
    chk("start_chnnl", chnnl, (w == 0) ? ch0 : ch1);
    chk("start_res",   res_out, m_res);
    if (spurious) begin cnv_cmplt = 1'b1; res = ~r; end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      if (drop_mid && i == 0) drop(w);
      chk("wait_ctl", {done1, done0, busy, strt_cnv}, 4'b0010);
      chk("wait_hold", {gnt, res_out}, {eg, m_res});
    end
    cnv_cmplt = 1'b1;
    res       = r;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    res       = RES_W'($urandom);
    m_res     = r;
    chk("done_pulse", {done1, done0}, eg);
    chk("done_res",   res_out, m_res);
    drop(w);
    @(negedge clk);
    chk("back_idle", {busy, gnt, done1, done0}, 0);
  endtask

  initial begin
    int w;
    rst_n = 1'b0; req0 = 0; req1 = 0; chnl0 = '0; chnl1 = '0; cnv_cmplt = 0; res = '0;
    pend0 = 0; pend1 = 0; ch0 = '0; ch1 = '0; m_last = 1; m_res = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {gnt, done0, done1, busy, strt_cnv, err}, 0);
    chk("rst_data", {chnnl, res_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", busy, 0);

    // Tie straight after reset: requester 0 first, then 1.
    raise(0, 3'd1); raise(1, 3'd6);
    serve(4, 12'h123, 0, 0);
    serve(4, 12'h456, 0, 0);

    // Single request, completion 10 cycles after the start strobe.
    raise(0, 3'd3);
    serve(10, 12'hFFF, 0, 0);

    // Both held high for four conversions: grants alternate.
    for (int k = 0; k < 4; k++) begin
      raise(0, CH_W'($urandom)); raise(1, CH_W'($urandom));
      serve($urandom_range(1, 6), (k % 2 == 0) ? 12'h3FF : 12'hFFF, 0, 0);
    end
    if (pend0) serve(2, 12'h0AA, 0, 0);
    if (pend1) serve(2, 12'h0BB, 0, 0);

    // Spurious completions in IDLE and START are ignored.
    raise(1, CH_W'($urandom));
    serve(5, RES_W'($urandom), 1, 0);

    // Reset in the middle of WAIT, with a completion arriving during reset.
    raise(0, 3'd5);
    w = pick();
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    cnv_cmplt = 1'b1; res = 12'hABC;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {gnt, done0, done1, busy, strt_cnv, err}, 0);
    chk("mid_rst_data", {chnnl, res_out}, 0);
    @(negedge clk);
    chk("mid_rst_hold", {done0, done1, res_out}, 0);
    cnv_cmplt = 1'b0;
    drop(w);
    m_last = 1; m_res = '0;
    rst_n = 1'b1;
    @(negedge clk);
    raise(0, 3'd2); raise(1, 3'd7);
    serve(3, 12'h5A5, 0, 0);
    serve(3, 12'hA5A, 0, 0);

    // Randomised traffic against the model.
    for (int k = 0; k < 30; k++) begin
      if (!pend0 && $urandom_range(0, 1) == 1) raise(0, CH_W'($urandom));
      if (!pend1 && $urandom_range(0, 1) == 1) raise(1, CH_W'($urandom));
      if (!pend0 && !pend1) raise($urandom_range(0, 1), CH_W'($urandom));
      serve($urandom_range(1, 12), RES_W'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    if (pend0 || pend1) serve(2, 12'h777, 0, 0);
    if (pend0 || pend1) serve(2, 12'h888, 0, 0);

    // Missing completion.
    raise(1, 3'd4);
    m_last = 1;
    @(negedge clk);
    chk("tmo_start", {strt_cnv, gnt}, 3'b110);
`ifdef A2D_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("tmo_wait", {err, done1, done0, busy}, 4'b0001);
    end
    @(negedge clk);
    chk("tmo_done", {err, done1, done0}, 3'b110);
    chk("tmo_res",  res_out, m_res);
    drop(1);
    @(negedge clk);
    chk("tmo_idle", {busy, err, gnt}, 0);
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("no_tmo_wait", {err, done1, done0, busy}, 4'b0001);
    end
    cnv_cmplt = 1'b1; res = 12'h321;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    m_res = 12'h321;
    chk("no_tmo_done", {err, done1, done0}, 3'b010);
    chk("no_tmo_res",  res_out, m_res);
    drop(1);
    @(negedge clk);
    chk("no_tmo_idle", {busy, gnt}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
